universal_shift_register_param: RTL

//   Parametrised universal shift register with a superset of the legacy 4-bit op set:

---
 rtl/usr_pkg.sv | 25 ++
 rtl/usr_if.sv | 29 ++
 rtl/usr_shift_unit.sv | 36 +++
 rtl/universal_shift_register_param.sv | 94 +++++++++
 4 files changed

// File: rtl/usr_pkg.sv
// Shared definitions for the universal shift register: operation codes,
// burst FSM states and the burst-eligibility predicate.
package usr_pkg;

    localparam logic [2:0] MODE_HOLD = 3'b000;
    localparam logic [2:0] MODE_SHR  = 3'b001;
    localparam logic [2:0] MODE_SHL  = 3'b010;
    localparam logic [2:0] MODE_LOAD = 3'b011;
    localparam logic [2:0] MODE_ROR  = 3'b100;
    localparam logic [2:0] MODE_ROL  = 3'b101;
    localparam logic [2:0] MODE_ASR  = 3'b110;
    localparam logic [2:0] MODE_RSVD = 3'b111;

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_BURST = 1'b1
    } usr_state_t;

    // Only shifting/rotating ops can be repeated by the burst engine.
    function automatic logic is_burst_mode(input logic [2:0] m);
        return (m == MODE_SHR) || (m == MODE_SHL) || (m == MODE_ROR) ||
               (m == MODE_ROL) || (m == MODE_ASR);
    endfunction

endpackage

// File: rtl/usr_if.sv
// Control/data bundle of the universal shift register; master drives the
// operation request, slave (the register) returns contents and burst status.
interface usr_if #(
    parameter int WIDTH = 4,
    parameter int CNT_W = $clog2(WIDTH) + 1
);
    logic             en;
    logic [2:0]       mode;
    logic [WIDTH-1:0] parin;
    logic             ser_in_msb;
    logic             ser_in_lsb;
    logic             start;
    logic [CNT_W-1:0] count;
    logic [WIDTH-1:0] out;
    logic             ser_out_lsb;
    logic             ser_out_msb;
    logic             busy;
    logic             done;

    modport master (
        output en, mode, parin, ser_in_msb, ser_in_lsb, start, count,
        input  out, ser_out_lsb, ser_out_msb, busy, done
    );

    modport slave (
        input  en, mode, parin, ser_in_msb, ser_in_lsb, start, count,
        output out, ser_out_lsb, ser_out_msb, busy, done
    );
endinterface

// File: rtl/usr_shift_unit.sv
// Combinational next-value generator for every register operation; shared by
// single-op and burst paths so both execute identical arithmetic.
module usr_shift_unit
    import usr_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic [2:0]       mode,
    input  logic [WIDTH-1:0] cur,
    input  logic             ser_in_msb,
    input  logic             ser_in_lsb,
    input  logic [WIDTH-1:0] parin,
    output logic [WIDTH-1:0] nxt
);

    // Arithmetic shift keeps the sign bit, so repeated use saturates to all-sign.
    function automatic logic [WIDTH-1:0] asr1(input logic [WIDTH-1:0] v);
        logic signed [WIDTH-1:0] s;
        s = signed'(v);
        return unsigned'(s >>> 1);
    endfunction

    always_comb begin
        nxt = cur;
        case (mode)
            MODE_SHR:  nxt = {ser_in_msb, cur[WIDTH-1:1]};
            MODE_SHL:  nxt = {cur[WIDTH-2:0], ser_in_lsb};
            MODE_LOAD: nxt = parin;
            MODE_ROR:  nxt = {cur[0], cur[WIDTH-1:1]};
            MODE_ROL:  nxt = {cur[WIDTH-2:0], cur[WIDTH-1]};
            MODE_ASR:  nxt = asr1(cur);
            default:   nxt = cur;
        endcase
    end

endmodule

// File: rtl/universal_shift_register_param.sv
// Parametrised universal shift register with a start/count burst engine that
// repeats one latched shift or rotate op and flags completion with a done pulse.
module universal_shift_register_param
    import usr_pkg::*;
#(
    parameter int WIDTH = 4,
    parameter int CNT_W = $clog2(WIDTH) + 1
) (
    input logic   clk,
    input logic   clr,
    usr_if.slave  bus
);

    usr_state_t       state_p0, state_nxt;
    logic [WIDTH-1:0] data_p0, data_nxt;
    logic [CNT_W-1:0] rem_p0, rem_nxt;
    logic [2:0]       bmode_p0, bmode_nxt;
    logic             done_p0, done_nxt;
    logic [2:0]       op_mode;
    logic [WIDTH-1:0] op_result;

    // During a burst the latched op drives the unit; live mode is ignored.
    assign op_mode = (state_p0 == ST_BURST) ? bmode_p0 : bus.mode;

    usr_shift_unit #(.WIDTH(WIDTH)) u_shift (
        .mode       (op_mode),
        .cur        (data_p0),
        .ser_in_msb (bus.ser_in_msb),
        .ser_in_lsb (bus.ser_in_lsb),
        .parin      (bus.parin),
        .nxt        (op_result)
    );

    // Stage p0: architectural register, burst FSM, remaining count, done flag
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            state_p0 <= ST_IDLE;
            data_p0  <= '0;
            rem_p0   <= '0;
            bmode_p0 <= MODE_HOLD;
            done_p0  <= 1'b0;
        end else begin
            state_p0 <= state_nxt;
            data_p0  <= data_nxt;
            rem_p0   <= rem_nxt;
            bmode_p0 <= bmode_nxt;
            done_p0  <= done_nxt;
        end
    end

    always_comb begin
        state_nxt = state_p0;
        data_nxt  = data_p0;
        rem_nxt   = rem_p0;
        bmode_nxt = bmode_p0;
        done_nxt  = done_p0;
        if (bus.en) begin
            done_nxt = 1'b0;
            data_nxt = op_result;
            case (state_p0)
                ST_IDLE: begin
                    if (bus.start && is_burst_mode(bus.mode)) begin
                        if (bus.count == '0) begin
                            data_nxt = data_p0;
                            done_nxt = 1'b1;
                        end else begin
                            bmode_nxt = bus.mode;
                            rem_nxt   = bus.count - CNT_W'(1);
                            if (bus.count == CNT_W'(1))
                                done_nxt = 1'b1;
                            else
                                state_nxt = ST_BURST;
                        end
                    end
                end
                ST_BURST: begin
                    rem_nxt = rem_p0 - CNT_W'(1);
                    if (rem_p0 == CNT_W'(1)) begin
                        state_nxt = ST_IDLE;
                        done_nxt  = 1'b1;
                    end
                end
                default: state_nxt = ST_IDLE;
            endcase
        end
    end

    assign bus.out         = data_p0;
    assign bus.ser_out_lsb = data_p0[0];
    assign bus.ser_out_msb = data_p0[WIDTH-1];
    assign bus.busy        = (state_p0 == ST_BURST);
    assign bus.done        = done_p0;

endmodule
